pkd_lane_tx: RTL and testbench

//   Transmit end of the packed-word lane: accepts one packed word per handshake and

---
 rtl/pkd_lane_tx.sv | 119 +++++++++++
 tb/tb_pkd_lane_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkd_lane_tx.sv
// pkd_lane_tx: serialises packed words MSB-first into LANE_W-bit lane beats.
// Optional beat parity when PKD_TX_PARITY_EN is defined.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   word handshake, in_word sampled on handshake
//   tx_valid/tx_ready   beat handshake toward the lane receiver
//   tx_data, tx_last    current beat, high on final beat of a word
//   tx_par              even parity of tx_data (0 when parity disabled)
//   word_cnt            words fully sent, wraps
module pkd_lane_tx #(
    parameter int WORD_W = 16,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [LANE_W-1:0] tx_data,
    output logic              tx_last,
    output logic              tx_par,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int BEATS = WORD_W / LANE_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    generate
        if ((WORD_W % LANE_W) != 0 || WORD_W < LANE_W) begin : g_bad_cfg
            $error("pkd_lane_tx: WORD_W must be a multiple of LANE_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_beat;

    // The beat on the lane is always the top slice of the shift register;
    // the register is cleared whenever no word is held, so tx_data reads 0.
    assign last_beat = (state_q == SEND) && (idx_q == LAST_IDX);
    assign tx_valid  = (state_q == SEND);
    assign tx_data   = shift_q[WORD_W-1 -: LANE_W];
    assign tx_last   = last_beat;
    assign in_ready  = (state_q == IDLE) || (last_beat && tx_ready);
    assign word_cnt  = cnt_q;

`ifdef PKD_TX_PARITY_EN
    assign tx_par = ^tx_data;
`else
    assign tx_par = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_word;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (last_beat) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // Reload on the same edge to avoid an idle beat.
                        if (in_valid) begin
                            shift_d = in_word;
                            idx_d   = '0;
                        end else begin
                            shift_d = '0;
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shift_q << LANE_W;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pkd_lane_tx.sv
// tb_pkd_lane_tx: directed table, corner sequences and randomized
// scoreboard checks for pkd_lane_tx (16/4/8) plus a 4/4 instance.
module tb_pkd_lane_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, tx_valid, tx_ready, tx_last, tx_par;
    logic [15:0] in_word;
    logic [3:0]  tx_data;
    logic [7:0]  word_cnt;

    logic        s_in_valid, s_in_ready, s_tx_valid, s_tx_ready;
    logic        s_tx_last, s_tx_par;
    logic [3:0]  s_in_word, s_tx_data;
    logic [7:0]  s_word_cnt;

    always #5 clk = ~clk;

    pkd_lane_tx #(.WORD_W(16), .LANE_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .tx_par(tx_par), .word_cnt(word_cnt)
    );

    pkd_lane_tx #(.WORD_W(4), .LANE_W(4), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_word(s_in_word),
        .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .tx_data(s_tx_data),
        .tx_last(s_tx_last), .tx_par(s_tx_par), .word_cnt(s_word_cnt)
    );

`ifdef PKD_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] word;
        logic [3:0]  beat [4];
        logic [3:0]  par;
    } vec_t;

    typedef struct packed {
        logic [3:0] d;
        logic       l;
    } beat_t;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt;
    vec_t       tbl [5];
    beat_t      mq [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic epar(logic [3:0] d);
        return PAR_ON ? ^d : 1'b0;
    endfunction

    task automatic send_row(vec_t v, bit do_chk);
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = v.word;
        tx_ready = 1'b1;
        #1;
        if (do_chk) chk("idle_in_ready", in_ready, 1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_word  = 16'($urandom);
            #1;
            if (do_chk) begin
                chk("row_valid", tx_valid, 1);
                chk("row_data", tx_data, v.beat[b]);
                chk("row_last", tx_last, (b == 3) ? 1 : 0);
                chk("row_par", tx_par, PAR_ON ? v.par[b] : 1'b0);
            end
        end
        @(negedge clk);
        #1;
        exp_cnt++;
        if (do_chk) begin
            chk("row_cnt", word_cnt, exp_cnt);
            chk("row_idle_valid", tx_valid, 0);
            chk("row_idle_data", tx_data, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        logic [3:0]  beats [8];
        logic [3:0]  prev;
        logic        exp_ir;
        beat_t       bt;

        tbl[0] = '{16'hA5C3, '{4'hA, 4'h5, 4'hC, 4'h3}, 4'b0000};
        tbl[1] = '{16'h1234, '{4'h1, 4'h2, 4'h3, 4'h4}, 4'b1011};
        tbl[2] = '{16'h7130, '{4'h7, 4'h1, 4'h3, 4'h0}, 4'b0011};
        tbl[3] = '{16'hFEDC, '{4'hF, 4'hE, 4'hD, 4'hC}, 4'b0110};
        tbl[4] = '{16'h0F0F, '{4'h0, 4'hF, 4'h0, 4'hF}, 4'b0000};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_word    = '0;
        tx_ready   = 1'b0;
        s_in_valid = 1'b0;
        s_in_word  = '0;
        s_tx_ready = 1'b0;
        exp_cnt    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_par", tx_par, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) send_row(tbl[i], 1'b1);

        // Backpressure on the second beat of A5C3.
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 16'hA5C3;
        tx_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_beat0", tx_data, 4'hA);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tx_ready = (c == 3);
            #1;
            chk("bp_hold_data", tx_data, 4'h5);
            chk("bp_hold_valid", tx_valid, 1);
            chk("bp_hold_last", tx_last, 0);
        end
        @(negedge clk);
        #1;
        chk("bp_beat2", tx_data, 4'hC);
        @(negedge clk);
        #1;
        chk("bp_beat3", tx_data, 4'h3);
        chk("bp_last", tx_last, 1);
        @(negedge clk);
        #1;
        exp_cnt++;
        chk("bp_cnt", word_cnt, exp_cnt);

        // Back-to-back words with in_valid held.
        beats = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hE, 4'hD, 4'hC};
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 16'h1234;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            in_word  = 16'hFEDC;
            in_valid = (b < 4);
            #1;
            chk("b2b_valid", tx_valid, 1);
            chk("b2b_data", tx_data, beats[b]);
            chk("b2b_in_ready", in_ready, (b == 3 || b == 7) ? 1 : 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        exp_cnt += 8'd2;
        chk("b2b_cnt", word_cnt, exp_cnt);
        chk("b2b_idle", tx_valid, 0);

        // Reset in the middle of BEEF.
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 16'hBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rm_beat0", tx_data, 4'hB);
        @(negedge clk);
        #1;
        chk("rm_beat1", tx_data, 4'hE);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", tx_valid, 0);
        chk("rm_cnt", word_cnt, 0);
        chk("rm_data", tx_data, 0);
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rm_no_partial", tx_valid, 0);
        end
        send_row(tbl[4], 1'b1);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_row(tbl[i % 5], 1'b0);
            if (i == 254) chk("wrap_255", word_cnt, 8'd255);
        end
        chk("wrap_0", word_cnt, exp_cnt);
        chk("wrap_0_abs", word_cnt, 8'd0);

        // Randomized traffic against a beat-queue model.
        do_reset();
        mq.delete();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            tx_ready = ($urandom % 4) != 0;
            in_word  = 16'($urandom);
            #1;
            exp_ir = (mq.size() == 0) || (mq.size() == 1 && tx_ready);
            chk("rnd_valid", tx_valid, (mq.size() != 0) ? 1 : 0);
            chk("rnd_in_ready", in_ready, exp_ir);
            chk("rnd_cnt", word_cnt, exp_cnt);
            if (mq.size() != 0) begin
                chk("rnd_data", tx_data, mq[0].d);
                chk("rnd_last", tx_last, mq[0].l);
                chk("rnd_par", tx_par, epar(mq[0].d));
                if (tx_ready) begin
                    bt = mq.pop_front();
                    if (bt.l) exp_cnt++;
                end
            end
            if (in_valid && exp_ir) begin
                for (int b = 0; b < 4; b++) begin
                    bt.d = in_word[15 - 4*b -: 4];
                    bt.l = (b == 3);
                    mq.push_back(bt);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        tx_ready = 1'b1;

        // Single-beat words: one word per cycle.
        s_in_valid = 1'b1;
        s_tx_ready = 1'b1;
        s_in_word  = 4'($urandom);
        prev       = s_in_word;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("s_valid", s_tx_valid, 1);
            chk("s_last", s_tx_last, 1);
            chk("s_data", s_tx_data, prev);
            chk("s_in_ready", s_in_ready, 1);
            chk("s_cnt", s_word_cnt, i - 1);
            s_in_word = 4'($urandom);
            prev      = s_in_word;
        end
        s_in_valid = 1'b0;

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
